// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory access unit: default widths,
// FSM state encoding and a small alignment helper.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Access FSM states (2-bit encoding)
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // Word accesses only: the two byte-offset bits must be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Cycle counter bounding how long one access may sit in REQ/WAIT_RSP.
// expired is raised on the last permitted cycle (count == LIMIT-1).
module dmem_timeout_counter #(
    parameter int LIMIT = 64,
    parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    // Clear has priority so a fresh access always starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + CW'(1);
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store port between the core datapath and an external
// data memory (valid/ready request, valid-only response). Stalls the core
// until the access finishes, flags misaligned words and bus timeouts.
module dmem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic              bus_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    logic [1:0] state, state_nxt;
    logic       op, aligned, expired, cnt_clear, cnt_enable;

    assign op      = mem_read | mem_write;
    assign aligned = word_aligned(address[1:0]);

    // Next-state decode; a progress event on the timeout cycle wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (op) state_nxt = aligned ? S_REQ : S_DONE;
            S_REQ:      if (req_ready) state_nxt = req_we ? S_DONE : S_WAIT_RSP;
                        else if (expired) state_nxt = S_DONE;
            S_WAIT_RSP: if (rsp_valid || expired) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Request channel: fields latched in IDLE and held until accept/timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: if (op && aligned) begin
                    req_valid <= 1'b1;
                    req_we    <= mem_write;
                    req_addr  <= address;
                    req_wdata <= write_data;
                end
                S_REQ: if (req_ready || expired) req_valid <= 1'b0;
                default: req_valid <= 1'b0;
            endcase
        end
    end

    // Completion status pulses and load data; errors zero read_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            read_data <= '0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: if (op && !aligned) begin
                    misalign  <= 1'b1;
                    read_data <= '0;
                end
                S_REQ: if (!req_ready && expired) begin
                    bus_err   <= 1'b1;
                    read_data <= '0;
                end
                S_WAIT_RSP: if (rsp_valid) begin
                    read_data <= rsp_rdata;
                end else if (expired) begin
                    bus_err   <= 1'b1;
                    read_data <= '0;
                end
                default: ;
            endcase
        end
    end

    assign cnt_clear  = (state == S_IDLE) && (state_nxt == S_REQ);
    assign cnt_enable = (state == S_REQ) || (state == S_WAIT_RSP);

    dmem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    assign stall = ((state == S_IDLE) && op) || (state == S_REQ) || (state == S_WAIT_RSP);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed table, randomized transactions
// against a cycle-count model, and reset/back-to-back sequences.
module tb_dmem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data, read_data;
    logic        stall, done, misalign, bus_err;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .stall(stall), .done(done), .misalign(misalign), .bus_err(bus_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    // dr: REQ cycles before req_ready; ds: WAIT_RSP cycles before rsp_valid
    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int          dr, ds;
        logic [31:0] rdata;
        int          exp_done;
        logic        exp_mis, exp_berr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[12];
    logic [31:0] mdl_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle of done (k=1 is the IDLE cycle with op) and results.
    function automatic vec_t predict(input vec_t v, inout logic [31:0] last);
        vec_t r = v;
        r.exp_mis = 1'b0; r.exp_berr = 1'b0;
        if (v.addr[1:0] != 2'b00) begin
            r.exp_done = 2; r.exp_mis = 1'b1; last = '0;
        end else if (v.wr) begin
            if (v.dr <= TO - 1) r.exp_done = 3 + v.dr;
            else begin r.exp_done = 2 + TO; r.exp_berr = 1'b1; last = '0; end
        end else begin
            if (v.dr + 1 + v.ds <= TO - 1) begin r.exp_done = 4 + v.dr + v.ds; last = v.rdata; end
            else begin r.exp_done = 2 + TO; r.exp_berr = 1'b1; last = '0; end
        end
        r.exp_rd = last;
        return r;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic rdy, input logic rv, input logic [31:0] rdt);
        mem_read = rd; mem_write = wr; address = a; write_data = wd;
        req_ready = rdy; rsp_valid = rv; rsp_rdata = rdt;
    endtask

    // Run one access from posedge+1; op held until the done cycle, then one idle cycle.
    task automatic run_txn(input vec_t v, input string tag);
        int  mn;
        logic in_req, exp_req, ld;
        mn = (v.dr < TO - 1) ? v.dr : TO - 1;
        ld = v.rd && !v.wr;
        for (int k = 1; k <= v.exp_done; k++) begin
            in_req = (v.addr[1:0] == 2'b00) && (k >= 2) && (k <= 2 + mn);
            drive(v.rd, v.wr, v.addr, v.wdata, (k == 2 + v.dr), 1'b0, $urandom);
            if (in_req && ($urandom_range(0, 1) == 1)) rsp_valid = 1'b1;  // must be ignored
            else if (ld && k == 3 + v.dr + v.ds) begin rsp_valid = 1'b1; rsp_rdata = v.rdata; end
            exp_req = in_req && !(v.addr[1:0] != 2'b00);
            @(negedge clk);
            chk({tag, ".stall"},     {31'd0, stall},     {31'd0, k < v.exp_done});
            chk({tag, ".done"},      {31'd0, done},      {31'd0, k == v.exp_done});
            chk({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, exp_req});
            chk({tag, ".misalign"},  {31'd0, misalign},  {31'd0, (k == v.exp_done) && v.exp_mis});
            chk({tag, ".bus_err"},   {31'd0, bus_err},   {31'd0, (k == v.exp_done) && v.exp_berr});
            if (exp_req) begin
                chk({tag, ".req_we"},   {31'd0, req_we}, {31'd0, v.wr});
                chk({tag, ".req_addr"}, req_addr, v.addr);
                if (v.wr) chk({tag, ".req_wdata"}, req_wdata, v.wdata);
            end
            if (k == v.exp_done) chk({tag, ".read_data"}, read_data, v.exp_rd);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk({tag, ".idle_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".idle_done"},  {31'd0, done},  32'd0);
        chk({tag, ".hold_rdata"}, read_data, v.exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = '{1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0, 0, 32'h0,          3, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h20, 32'h0,        2, 0, 32'h12345678,   6, 1'b0, 1'b0, 32'h12345678};
        tbl[2]  = '{1'b1, 1'b0, 32'h22, 32'h0,        0, 0, 32'hFFFF0000,   2, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h8,  32'h55,      99, 0, 32'h0,         10, 1'b0, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 32'h4,  32'h77,       0, 0, 32'h0,          3, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h40, 32'h0,        0, 0, 32'h0000A5A5,   4, 1'b0, 1'b0, 32'h0000A5A5};
        tbl[6]  = '{1'b0, 1'b1, 32'h80, 32'h99,       7, 0, 32'h0,         10, 1'b0, 1'b0, 32'h0000A5A5};
        tbl[7]  = '{1'b1, 1'b0, 32'h44, 32'h0,        2, 4, 32'h11112222,  10, 1'b0, 1'b0, 32'h11112222};
        tbl[8]  = '{1'b1, 1'b0, 32'h48, 32'h0,        2, 5, 32'h33334444,  10, 1'b0, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h4C, 32'h0,        1, 0, 32'h55556666,   5, 1'b0, 1'b0, 32'h55556666};
        tbl[10] = '{1'b0, 1'b1, 32'h13, 32'h1,        0, 0, 32'h0,          2, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h60, 32'h0,       99, 0, 32'h0,         10, 1'b0, 1'b1, 32'h0};

        // Reset state
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst.misalign", {31'd0, misalign}, 32'd0);
        chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst.read_data", read_data, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
        mdl_rd = tbl[11].exp_rd;

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            v.rd = (sel != 1); v.wr = (sel != 0);
            v.addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 4) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
            v.wdata = $urandom; v.rdata = $urandom;
            v.dr = $urandom_range(0, 9); v.ds = $urandom_range(0, 6);
            v = predict(v, mdl_rd);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Op held through DONE starts the next access; then reset while in REQ
        drive(1'b1, 1'b0, 32'h30, '0, 1'b0, 1'b0, '0);
        @(negedge clk); chk("b2b.k1_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; req_ready = 1'b1;
        @(negedge clk); chk("b2b.k2_req_valid", {31'd0, req_valid}, 32'd1);
        @(posedge clk); #1; req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("b2b.k3_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; rsp_valid = 1'b0;
        @(negedge clk);
        chk("b2b.k4_done", {31'd0, done}, 32'd1);
        chk("b2b.k4_stall", {31'd0, stall}, 32'd0);
        chk("b2b.k4_rdata", read_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.k5_stall", {31'd0, stall}, 32'd1);
        chk("b2b.k5_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.k6_req_valid", {31'd0, req_valid}, 32'd1);
        #2;
        reset = 1'b0; mem_read = 1'b0;
        #1;
        chk("rstreq.req_valid", {31'd0, req_valid}, 32'd0);
        chk("rstreq.stall", {31'd0, stall}, 32'd0);
        chk("rstreq.read_data", read_data, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Reset while in WAIT_RSP; the late response must be discarded
        drive(1'b1, 1'b0, 32'h50, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1; req_ready = 1'b1;
        @(posedge clk); #1; req_ready = 1'b0;
        @(negedge clk); chk("rstwait.pre_stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0; mem_read = 1'b0;
        #1;
        chk("rstwait.stall", {31'd0, stall}, 32'd0);
        chk("rstwait.done", {31'd0, done}, 32'd0);
        chk("rstwait.req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; rsp_valid = 1'b1; rsp_rdata = 32'h87654321;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("rstwait.after_stall", {31'd0, stall}, 32'd0);
            chk("rstwait.after_done", {31'd0, done}, 32'd0);
            chk("rstwait.after_rdata", read_data, 32'd0);
            @(posedge clk); #1;
        end
        rsp_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
